conv_rt_param_regs: RTL and testbench
=====================================

Name: conv_rt_param_regs

Overview:
- APB3 responder holding the generic-conv runtime parameters (calc, group-conv, feature-map, kernel and buffer fields) and the MAC-array/packer enables.
- Software writes a staging bank. A start command copies staging into an active bank, which the conv datapath consumes, and runs a busy/done handshake with the datapath.
- Sits between the host bus and the conv accelerator top. It is the DUT-side counterpart of the simulation config driver.

Parameters:
- ID_VALUE, 32'h434E_5631, read-only value at offset 0x40.
- ADDR_W, 8, APB address width (byte address).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  ADDR_W  byte address; [1:0] ignored
- pwdata  in  32  write data
- pready  out  1  constant 1 (no wait states)
- prdata  out  32  read data
- pslverr  out  1  error response
- en_mac_array  out  1  MAC-array enable, CTRL[1]
- en_packer  out  1  packer enable, CTRL[2]
- rt_param  out  438  active parameter bundle, type conv_rt_param_t
- blk_start  out  1  one-cycle start pulse to datapath
- blk_done  in  1  datapath completion pulse
- irq  out  1  done interrupt, level

Behaviour:
- Access cycle = psel & penable. Setup phase has no effect. pready is always 1.
- Register map (word offsets). Fields are packed LSB-first in listed order; unlisted bits read 0 and ignore writes.
  - 0x00 CTRL: start[0] (W1, self-clearing, reads 0), en_mac_array[1], en_packer[2], irq_en[3], busy[8] (RO), done[9] (W1C), start_err[10] (W1C).
  - 0x04: calfmt[1:0], vstride[4:2], hstride[7:5], cal_round[11:8], is_grp_conv_mode[12].
  - 0x08: group_n[15:0], n_foreach_group[31:16].
  - 0x0C: data_size_foreach_group.
  - 0x10: ifmap_baseaddr.
  - 0x14: ofmap_baseaddr.
  - 0x18: ifmap_w[15:0], fmap_chn_n[31:16].
  - 0x1C: ifmap_size[23:0], ofmap_data_type[25:24].
  - 0x20: fmap_ext_i_bottom[15:0], ext_pad_left[18:16], ext_pad_top[21:19], inner_pad_lr[24:22], inner_pad_tb[27:25].
  - 0x24: ofmap_w[15:0], ofmap_h[31:16].
  - 0x28: kernal_wgt_baseaddr.
  - 0x2C: kernal_shape[2:0], dil_hzt_n[6:3], w_dilated[11:7], dil_vtc_n[15:12], h_dilated[20:16], max_wgtblk_w[26:21].
  - 0x30: kernal_chn_n[15:0], cgrpn_foreach_kernal_set[31:16].
  - 0x34: kernal_num_n[15:0], kernal_set_n[31:16].
  - 0x38: fmbufbankn[7:0], fmbufcoln[11:8], fmbufrown[21:12], kbufgrpsz[24:22], sfc_n_each_wgtblk[27:25].
  - 0x3C: kbufgrpn[7:0], mid_res_item_n_foreach_row[23:8], mid_res_buf_row_n_bufferable[27:24].
  - 0x40: ID (RO; writes give pslverr=1, no effect).
- Unmapped address: pslverr=1 in the access cycle, prdata=0, no state change.
- Reads are combinational from staging/CTRL in the access cycle.
- Writes update staging at the clock edge ending the access cycle. A param write while busy updates staging only; rt_param holds.
- State machine:
  - IDLE → RUN when a CTRL write with start=1 occurs and busy=0. At the next edge: rt_param<=staging, busy<=1, blk_start=1 for exactly one cycle, done<=0.
  - Start write while busy=1: ignored, start_err<=1, rt_param and busy unchanged.
  - RUN → IDLE on blk_done=1. At the next edge: busy<=0, done<=1.
  - blk_done in IDLE is ignored.
- Simultaneous events:
  - blk_done and a start write in the same cycle: blk_done completes; start is judged on pre-edge busy=1, so it is rejected with start_err.
  - W1C of done in the same cycle as a done-set event: set wins.
- irq = done & irq_en (registered inputs, combinational AND).
- en_mac_array/en_packer follow CTRL writes immediately (not shadowed).
- Reset (any time, including RUN): all staging, active, CTRL bits, busy, done, start_err, blk_start, irq = 0. prdata=0, pslverr=0.

Decomposition:
- Package conv_rt_param_pkg:
  - conv_rt_param_t packed struct (438 bits, field order as map).
  - Register offset localparams.
  - CTRL bit-index constants.
- One sub-module, conv_rt_param_ctrl_fsm: IDLE/RUN, blk_start pulse, busy/done/start_err/irq.
- Field decode and staging live in the top.

Test Plan:
- Reset release → prdata from 0x00 reads 0, rt_param=0, irq=0. Read 0x40 returns 32'h434E_5631, pslverr=0.
- Write 0x18=32'h0003_001F, then CTRL=0x1 → blk_start high exactly one cycle after the access. rt_param.ifmap_w=31, fmap_chn_n=3. CTRL read shows busy=1.
- While busy, write 0x18=32'h0007_003F → readback 0x0007_003F. rt_param still ifmap_w=31. Another start sets start_err=1 with no blk_start.
- Write CTRL=0x8 (irq_en), then pulse blk_done → next cycle busy=0, done=1, irq=1. Write CTRL=0x208 (W1C done) → irq=0.
- Same-cycle blk_done and start write → busy clears, start_err=1, no blk_start. Write to 0x44 → pslverr=1, nothing changes.
- Assert rst mid-RUN → busy, rt_param, en_mac_array immediately 0 (asynchronous). After release, a new start works normally.

Source files
------------

// File: rtl/conv_rt_param_pkg.sv
// Shared types and constants for the conv runtime-parameter register block.
// The parameter bundle packs the 0x04 fields at the LSB and the 0x3C fields at the MSB.
package conv_rt_param_pkg;

  typedef struct packed {
    logic [3:0]  mid_res_buf_row_n_bufferable;
    logic [15:0] mid_res_item_n_foreach_row;
    logic [7:0]  kbufgrpn;
    logic [2:0]  sfc_n_each_wgtblk;
    logic [2:0]  kbufgrpsz;
    logic [9:0]  fmbufrown;
    logic [3:0]  fmbufcoln;
    logic [7:0]  fmbufbankn;
    logic [15:0] kernal_set_n;
    logic [15:0] kernal_num_n;
    logic [15:0] cgrpn_foreach_kernal_set;
    logic [15:0] kernal_chn_n;
    logic [5:0]  max_wgtblk_w;
    logic [4:0]  h_dilated;
    logic [3:0]  dil_vtc_n;
    logic [4:0]  w_dilated;
    logic [3:0]  dil_hzt_n;
    logic [2:0]  kernal_shape;
    logic [31:0] kernal_wgt_baseaddr;
    logic [15:0] ofmap_h;
    logic [15:0] ofmap_w;
    logic [2:0]  inner_pad_tb;
    logic [2:0]  inner_pad_lr;
    logic [2:0]  ext_pad_top;
    logic [2:0]  ext_pad_left;
    logic [15:0] fmap_ext_i_bottom;
    logic [1:0]  ofmap_data_type;
    logic [23:0] ifmap_size;
    logic [15:0] fmap_chn_n;
    logic [15:0] ifmap_w;
    logic [31:0] ofmap_baseaddr;
    logic [31:0] ifmap_baseaddr;
    logic [31:0] data_size_foreach_group;
    logic [15:0] n_foreach_group;
    logic [15:0] group_n;
    logic        is_grp_conv_mode;
    logic [3:0]  cal_round;
    logic [2:0]  hstride;
    logic [2:0]  vstride;
    logic [1:0]  calfmt;
  } conv_rt_param_t;

  typedef enum logic {ST_IDLE, ST_RUN} fsm_state_e;

  localparam logic [7:0] OFS_CTRL = 8'h00;
  localparam logic [7:0] OFS_CALC = 8'h04;
  localparam logic [7:0] OFS_LAST = 8'h3C;
  localparam logic [7:0] OFS_ID   = 8'h40;

  localparam int CTRL_START  = 0;
  localparam int CTRL_EN_MAC = 1;
  localparam int CTRL_EN_PK  = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_BUSY   = 8;
  localparam int CTRL_DONE   = 9;
  localparam int CTRL_ERR    = 10;

  // Writable bits of each staging word, indexed by word offset (0x04 -> 1).
  function automatic logic [31:0] stage_mask(input logic [3:0] idx);
    case (idx)
      4'd1:                  stage_mask = 32'h0000_1FFF;
      4'd7:                  stage_mask = 32'h03FF_FFFF;
      4'd8, 4'd14, 4'd15:    stage_mask = 32'h0FFF_FFFF;
      4'd11:                 stage_mask = 32'h07FF_FFFF;
      4'd0:                  stage_mask = 32'h0000_0000;
      default:               stage_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/conv_rt_param_ctrl_fsm.sv
// Start/done handshake with the conv datapath: IDLE/RUN state, start pulse,
// sticky done and start-error flags, and the level interrupt.
module conv_rt_param_ctrl_fsm
  import conv_rt_param_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start_wr,
  input  logic i_done_clr,
  input  logic i_err_clr,
  input  logic i_blk_done,
  input  logic i_irq_en,
  output logic o_busy,
  output logic o_done,
  output logic o_start_err,
  output logic o_irq,
  output logic o_blk_start,
  output logic o_load
);

  fsm_state_e r_state;
  fsm_state_e w_next;
  logic       w_load;
  logic       w_done_set;
  logic       w_err_set;
  logic       r_done;
  logic       r_err;
  logic       r_blk_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // A start seen while running is judged on the pre-edge state, even if the
  // datapath finishes in the same cycle.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start_wr) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_start_wr) w_err_set = 1'b1;
        if (i_blk_done) begin
          w_done_set = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Set events take priority over software W1C clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_blk_start <= 1'b0;
    end else begin
      r_blk_start <= w_load;
      if (w_done_set)                r_done <= 1'b1;
      else if (w_load || i_done_clr) r_done <= 1'b0;
      if (w_err_set)                 r_err  <= 1'b1;
      else if (i_err_clr)            r_err  <= 1'b0;
    end
  end

  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = r_done;
  assign o_start_err = r_err;
  assign o_irq       = r_done & i_irq_en;
  assign o_blk_start = r_blk_start;
  assign o_load      = w_load;

endmodule

// File: rtl/conv_rt_param_regs.sv
// APB3 register block for the conv runtime parameters: staging bank written by
// software, active bank loaded on start, and the datapath handshake.
module conv_rt_param_regs
  import conv_rt_param_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h434E_5631,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic              en_mac_array,
  output logic              en_packer,
  output conv_rt_param_t    rt_param,
  output logic              blk_start,
  input  logic              blk_done,
  output logic              irq
);

  logic [31:0]       r_stage [1:15];
  conv_rt_param_t    r_active;
  logic              r_en_mac;
  logic              r_en_pk;
  logic              r_irq_en;

  logic              w_access;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-3:0] w_word;
  logic [3:0]        w_idx;
  logic              w_is_ctrl;
  logic              w_is_stage;
  logic              w_is_id;
  logic              w_ctrl_wr;
  logic              w_busy;
  logic              w_done;
  logic              w_err;
  logic              w_load;
  logic [31:0]       w_prdata;
  logic              w_unused_addr;
  conv_rt_param_t    w_stage_bundle;

  assign w_access      = psel & penable;
  assign w_wr          = w_access & pwrite;
  assign w_rd          = w_access & ~pwrite;
  assign w_word        = paddr[ADDR_W-1:2];
  assign w_idx         = w_word[3:0];
  assign w_unused_addr = ^paddr[1:0];
  assign w_is_ctrl     = (w_word == (ADDR_W-2)'(OFS_CTRL >> 2));
  assign w_is_stage    = (w_word >= (ADDR_W-2)'(OFS_CALC >> 2)) && (w_word <= (ADDR_W-2)'(OFS_LAST >> 2));
  assign w_is_id       = (w_word == (ADDR_W-2)'(OFS_ID >> 2));
  assign w_ctrl_wr     = w_wr & w_is_ctrl;

  // Masked bits of each staging word are dropped when building the bundle.
  assign w_stage_bundle = {r_stage[15][27:0], r_stage[14][27:0], r_stage[13], r_stage[12],
                           r_stage[11][26:0], r_stage[10], r_stage[9], r_stage[8][27:0],
                           r_stage[7][25:0], r_stage[6], r_stage[5], r_stage[4],
                           r_stage[3], r_stage[2], r_stage[1][12:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 15; i++) r_stage[i] <= '0;
    end else if (w_wr && w_is_stage) begin
      r_stage[w_idx] <= pwdata & stage_mask(w_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_mac <= 1'b0;
      r_en_pk  <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en_mac <= pwdata[CTRL_EN_MAC];
      r_en_pk  <= pwdata[CTRL_EN_PK];
      r_irq_en <= pwdata[CTRL_IRQ_EN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_active <= '0;
    else if (w_load) r_active <= w_stage_bundle;
  end

  conv_rt_param_ctrl_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_start_wr  (w_ctrl_wr & pwdata[CTRL_START]),
    .i_done_clr  (w_ctrl_wr & pwdata[CTRL_DONE]),
    .i_err_clr   (w_ctrl_wr & pwdata[CTRL_ERR]),
    .i_blk_done  (blk_done),
    .i_irq_en    (r_irq_en),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_start_err (w_err),
    .o_irq       (irq),
    .o_blk_start (blk_start),
    .o_load      (w_load)
  );

  always_comb begin
    w_prdata = 32'h0;
    if (!rst && w_rd) begin
      if (w_is_ctrl) begin
        w_prdata[CTRL_EN_MAC] = r_en_mac;
        w_prdata[CTRL_EN_PK]  = r_en_pk;
        w_prdata[CTRL_IRQ_EN] = r_irq_en;
        w_prdata[CTRL_BUSY]   = w_busy;
        w_prdata[CTRL_DONE]   = w_done;
        w_prdata[CTRL_ERR]    = w_err;
      end else if (w_is_stage) begin
        w_prdata = r_stage[w_idx];
      end else if (w_is_id) begin
        w_prdata = ID_VALUE;
      end
    end
  end

  assign prdata       = w_prdata;
  assign pslverr      = ~rst & w_access & (~(w_is_ctrl | w_is_stage | w_is_id) | (w_is_id & pwrite));
  assign pready       = 1'b1 | w_unused_addr;
  assign en_mac_array = r_en_mac;
  assign en_packer    = r_en_pk;
  assign rt_param     = r_active;

endmodule

// File: tb/tb_conv_rt_param_regs.sv
// Directed bench for conv_rt_param_regs; expected values go into a scoreboard
// queue as stimulus is applied and are popped when the DUT output is sampled.
module tb_conv_rt_param_regs;
  import conv_rt_param_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           psel = 1'b0;
  logic           penable = 1'b0;
  logic           pwrite = 1'b0;
  logic [7:0]     paddr = 8'h0;
  logic [31:0]    pwdata = 32'h0;
  logic           pready;
  logic [31:0]    prdata;
  logic           pslverr;
  logic           en_mac_array;
  logic           en_packer;
  conv_rt_param_t rt_param;
  logic           blk_start;
  logic           blk_done = 1'b0;
  logic           irq;

  typedef struct {
    string        tag;
    logic [437:0] exp;
  } exp_t;

  exp_t        sbQ[$];
  int          testsRun = 0;
  int          failCount = 0;
  logic [31:0] rdData;
  logic        rdErr;
  logic        wrErr;
  conv_rt_param_t expParam;

  localparam logic [31:0] ID_EXP = 32'h434E_5631;

  conv_rt_param_regs #(.ID_VALUE(32'h434E_5631), .ADDR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pready       (pready),
    .prdata       (prdata),
    .pslverr      (pslverr),
    .en_mac_array (en_mac_array),
    .en_packer    (en_packer),
    .rt_param     (rt_param),
    .blk_start    (blk_start),
    .blk_done     (blk_done),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic expectVal(input string tag, input logic [437:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [437:0] observed);
    exp_t e;
    testsRun++;
    if (sbQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=<none>", observed);
    end else begin
      e = sbQ.pop_front();
      assert (observed === e.exp)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic apbWrite(input logic [7:0] addr, input logic [31:0] data,
                          input logic withDone, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    blk_done = withDone;
    #1;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; blk_done = 1'b0;
  endtask

  task automatic apbRead(input logic [7:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulseDone();
    @(posedge clk); #1;
    blk_done = 1'b1;
    @(posedge clk); #1;
    blk_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expectVal("reset_rt_param", '0);        checkOutput(rt_param);
    expectVal("reset_irq", '0);             checkOutput(irq);
    expectVal("reset_blk_start", '0);       checkOutput(blk_start);
    expectVal("reset_pready", 1);           checkOutput(pready);
    apbRead(8'h00, rdData, rdErr);
    expectVal("reset_ctrl", 32'h0);         checkOutput(rdData);
    apbRead(8'h40, rdData, rdErr);
    expectVal("id_value", ID_EXP);          checkOutput(rdData);
    expectVal("id_pslverr", 0);             checkOutput(rdErr);

    // Stage parameters at both ends of the bundle, then start
    apbWrite(8'h18, 32'h0003_001F, 1'b0, wrErr);
    expectVal("wr18_pslverr", 0);           checkOutput(wrErr);
    apbWrite(8'h04, 32'hFFFF_FFFF, 1'b0, wrErr);
    apbWrite(8'h3C, 32'hFABC_DEF1, 1'b0, wrErr);
    apbRead(8'h04, rdData, rdErr);
    expectVal("mask_04", 32'h0000_1FFF);    checkOutput(rdData);
    apbRead(8'h3C, rdData, rdErr);
    expectVal("mask_3c", 32'h0ABC_DEF1);    checkOutput(rdData);
    expectVal("pre_start_rt_param", '0);    checkOutput(rt_param);
    apbWrite(8'h00, 32'h0000_0001, 1'b0, wrErr);
    expectVal("start_pulse", 1);            checkOutput(blk_start);
    expParam = '0;
    expParam.ifmap_w = 16'd31;
    expParam.fmap_chn_n = 16'd3;
    expParam.calfmt = 2'h3;
    expParam.vstride = 3'h7;
    expParam.hstride = 3'h7;
    expParam.cal_round = 4'hF;
    expParam.is_grp_conv_mode = 1'b1;
    expParam.kbufgrpn = 8'hF1;
    expParam.mid_res_item_n_foreach_row = 16'hBCDE;
    expParam.mid_res_buf_row_n_bufferable = 4'hA;
    expectVal("start_rt_param", expParam);  checkOutput(rt_param);
    @(posedge clk); #1;
    expectVal("start_pulse_end", 0);        checkOutput(blk_start);
    apbRead(8'h00, rdData, rdErr);
    expectVal("ctrl_busy", 32'h100);        checkOutput(rdData);

    // Writes while busy touch staging only; a second start is rejected
    apbWrite(8'h18, 32'h0007_003F, 1'b0, wrErr);
    apbRead(8'h18, rdData, rdErr);
    expectVal("busy_stage_readback", 32'h0007_003F); checkOutput(rdData);
    expectVal("busy_rt_hold", 16'd31);      checkOutput(rt_param.ifmap_w);
    apbWrite(8'h00, 32'h0000_0001, 1'b0, wrErr);
    expectVal("busy_start_no_pulse", 0);    checkOutput(blk_start);
    apbRead(8'h00, rdData, rdErr);
    expectVal("ctrl_start_err", 32'h500);   checkOutput(rdData);

    // Completion, interrupt and W1C of done
    apbWrite(8'h00, 32'h0000_0008, 1'b0, wrErr);
    pulseDone();
    expectVal("done_irq", 1);               checkOutput(irq);
    apbRead(8'h00, rdData, rdErr);
    expectVal("ctrl_done", 32'h608);        checkOutput(rdData);
    apbWrite(8'h00, 32'h0000_0208, 1'b0, wrErr);
    expectVal("w1c_irq", 0);                checkOutput(irq);
    apbRead(8'h00, rdData, rdErr);
    expectVal("ctrl_after_w1c", 32'h408);   checkOutput(rdData);
    apbWrite(8'h00, 32'h0000_0408, 1'b0, wrErr);
    apbRead(8'h00, rdData, rdErr);
    expectVal("ctrl_err_clr", 32'h008);     checkOutput(rdData);

    // Restart picks up the staged value, then blk_done and start collide
    apbWrite(8'h00, 32'h0000_0009, 1'b0, wrErr);
    expectVal("restart_pulse", 1);          checkOutput(blk_start);
    expectVal("restart_ifmap_w", 16'd63);   checkOutput(rt_param.ifmap_w);
    expectVal("restart_chn_n", 16'd7);      checkOutput(rt_param.fmap_chn_n);
    apbWrite(8'h00, 32'h0000_0009, 1'b1, wrErr);
    expectVal("collide_no_pulse", 0);       checkOutput(blk_start);
    expectVal("collide_irq", 1);            checkOutput(irq);
    apbRead(8'h00, rdData, rdErr);
    expectVal("collide_ctrl", 32'h608);     checkOutput(rdData);

    // Error responses
    apbWrite(8'h44, 32'hDEAD_BEEF, 1'b0, wrErr);
    expectVal("unmapped_wr_err", 1);        checkOutput(wrErr);
    apbRead(8'h44, rdData, rdErr);
    expectVal("unmapped_rd_err", 1);        checkOutput(rdErr);
    expectVal("unmapped_rd_data", 32'h0);   checkOutput(rdData);
    apbWrite(8'h40, 32'h1234_5678, 1'b0, wrErr);
    expectVal("id_wr_err", 1);              checkOutput(wrErr);
    apbRead(8'h40, rdData, rdErr);
    expectVal("id_unchanged", ID_EXP);      checkOutput(rdData);
    apbRead(8'h00, rdData, rdErr);
    expectVal("ctrl_unchanged", 32'h608);   checkOutput(rdData);

    // Asynchronous reset in the middle of a run
    apbWrite(8'h00, 32'h0000_0003, 1'b0, wrErr);
    expectVal("run_en_mac", 1);             checkOutput(en_mac_array);
    expectVal("run_irq_off", 0);            checkOutput(irq);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    expectVal("async_rt_param", '0);        checkOutput(rt_param);
    expectVal("async_en_mac", 0);           checkOutput(en_mac_array);
    @(posedge clk); #1;
    rst = 1'b0;
    apbRead(8'h00, rdData, rdErr);
    expectVal("post_reset_ctrl", 32'h0);    checkOutput(rdData);
    apbRead(8'h18, rdData, rdErr);
    expectVal("post_reset_stage", 32'h0);   checkOutput(rdData);
    apbWrite(8'h18, 32'h0000_0005, 1'b0, wrErr);
    apbWrite(8'h00, 32'h0000_0001, 1'b0, wrErr);
    expectVal("post_reset_pulse", 1);       checkOutput(blk_start);
    expectVal("post_reset_ifmap_w", 16'd5); checkOutput(rt_param.ifmap_w);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
